// File: rtl/branch_info_table_if.sv
// Fetch-lookup and execute-update bundle for the branch info table.
// Latency: none (wires only); the table answers lookups in the same cycle.
// Backpressure: upd_valid/upd_ready handshake on the update path; lookup is never stalled.
interface branch_info_table_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int PARA_WIDTH = 10
) ();
    logic [ADDR_WIDTH-1:0] pc_now;
    logic                  exist1;
    logic                  exist2;
    logic [ADDR_WIDTH-1:0] info1;
    logic [ADDR_WIDTH-1:0] info2;
    logic                  past_vld1;
    logic                  past_vld2;
    logic [PARA_WIDTH-1:0] past1;
    logic [PARA_WIDTH-1:0] past2;
    logic                  upd_valid;
    logic                  upd_ready;
    logic [ADDR_WIDTH-1:0] upd_pc;
    logic                  upd_taken;
    logic [ADDR_WIDTH-1:0] upd_target;

    // Fetch/execute side.
    modport master (
        output pc_now, upd_valid, upd_pc, upd_taken, upd_target,
        input  exist1, exist2, info1, info2, past_vld1, past_vld2, past1, past2, upd_ready
    );

    // Table side.
    modport slave (
        input  pc_now, upd_valid, upd_pc, upd_taken, upd_target,
        output exist1, exist2, info1, info2, past_vld1, past_vld2, past1, past2, upd_ready
    );
endinterface

// File: rtl/branch_info_table.sv
// Branch info table: per fetch pair tag/target/pattern, comb lookup, trained via a 2-entry queue.
// Latency: lookup 0 cycles; update visible the cycle after its pop (same cycle with BIT_WRITE_BYPASS_EN).
// Backpressure: upd_ready low while the queue holds 2 entries; en=0 freezes everything.
module branch_info_table #(
    parameter int ADDR_WIDTH = 32,
    parameter int HASH_DEPTH = 5,
    parameter int HASH_WIDTH = 24,
    parameter int PARA_WIDTH = 10
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                en,
    input  logic                clear,
    output logic                busy,
    branch_info_table_if.slave  bus
);
    localparam int SETS    = 1 << HASH_DEPTH;
    localparam int TAG_LSB = HASH_DEPTH + 3;
    localparam int TAG_MSB = HASH_WIDTH + HASH_DEPTH + 2;
    // Fresh allocation: history 00, every counter weakly not-taken.
    localparam logic [PARA_WIDTH-1:0] PAT_ALLOC = 10'b00_01_01_01_01;

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    typedef struct packed {
        logic [HASH_WIDTH-1:0] tag;
        logic [ADDR_WIDTH-1:0] target;
        logic [PARA_WIDTH-1:0] pat;
    } ent_t;

    typedef struct packed {
        logic [HASH_WIDTH-1:0] tag;
        logic [HASH_DEPTH-1:0] set;
        logic                  slot;
        logic                  taken;
        logic [ADDR_WIDTH-1:0] target;
    } upd_t;

    state_t                    state_q, state_d;
    logic [HASH_DEPTH-1:0]     ptr_q, ptr_d;
    logic                      sweep_clr;

    upd_t                      q_mem [2];
    upd_t                      q_in, head;
    logic                      q_wr, q_rd;
    logic [1:0]                q_cnt;
    logic                      push, pop;

    ent_t                      mem [SETS][2];
    logic [SETS-1:0][1:0]      vld_q;
    logic [SETS-1:0][1:0]      pvld_q;

    ent_t                      cur, wr_ent;
    logic                      hit, wr_any;
    logic [1:0]                hist;
    logic [3:0][1:0]           ctrs;

    logic [HASH_DEPTH-1:0]     l_set;
    logic [HASH_WIDTH-1:0]     l_tag;
    ent_t                      lk0, lk1;
    logic [1:0]                lv, lp;

    // pc[2] only steers updates; lookups return both slots of the pair.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.pc_now[2:0], bus.upd_pc[1:0]};

    // Sweep FSM: clear restarts the sweep; the last set hands over to RUN.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sweep_clr = 1'b0;
        if (en) begin
            if (clear) begin
                state_d = ST_INIT;
                ptr_d   = '0;
            end else if (state_q == ST_INIT) begin
                sweep_clr = 1'b1;
                ptr_d     = ptr_q + HASH_DEPTH'(1);
                if (&ptr_q) begin
                    state_d = ST_RUN;
                end
            end
        end
    end

    // Sweep FSM state and pointer registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign busy          = (state_q == ST_INIT);
    assign bus.upd_ready = (q_cnt != 2'd2);
    // A clear cycle drops any incoming update along with the queued ones.
    assign push = en & ~clear & bus.upd_valid & bus.upd_ready;
    assign pop  = en & ~clear & (state_q == ST_RUN) & (q_cnt != 2'd0);
    assign q_in = '{tag: bus.upd_pc[TAG_MSB:TAG_LSB], set: bus.upd_pc[HASH_DEPTH+2:3],
                    slot: bus.upd_pc[2], taken: bus.upd_taken, target: bus.upd_target};
    assign head = q_mem[q_rd];

    // Queue pointers and occupancy; clear flushes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_wr  <= 1'b0;
            q_rd  <= 1'b0;
            q_cnt <= 2'd0;
        end else if (en && clear) begin
            q_wr  <= 1'b0;
            q_rd  <= 1'b0;
            q_cnt <= 2'd0;
        end else begin
            if (push) q_wr <= ~q_wr;
            if (pop)  q_rd <= ~q_rd;
            case ({push, pop})
                2'b10:   q_cnt <= q_cnt + 2'd1;
                2'b01:   q_cnt <= q_cnt - 2'd1;
                default: q_cnt <= q_cnt;
            endcase
        end
    end

    // Queue payload storage.
    always_ff @(posedge clk) begin
        if (push) q_mem[q_wr] <= q_in;
    end

    // Training: saturating counter selected by history, or allocation on a taken miss.
    always_comb begin
        cur  = mem[head.set][head.slot];
        hit  = vld_q[head.set][head.slot] && (cur.tag == head.tag);
        hist = cur.pat[9:8];
        ctrs = cur.pat[7:0];
        if (head.taken) begin
            if (ctrs[hist] != 2'b11) ctrs[hist] = ctrs[hist] + 2'd1;
        end else begin
            if (ctrs[hist] != 2'b00) ctrs[hist] = ctrs[hist] - 2'd1;
        end
        wr_ent = cur;
        if (hit) begin
            wr_ent.pat = {hist[0], head.taken, ctrs};
            if (head.taken) wr_ent.target = head.target;
        end else begin
            wr_ent.tag    = head.tag;
            wr_ent.target = head.target;
            wr_ent.pat    = PAT_ALLOC;
        end
        wr_any = pop & (hit | head.taken);
    end

    // Entry payload array.
    always_ff @(posedge clk) begin
        if (wr_any) mem[head.set][head.slot] <= wr_ent;
    end

    // Valid and trained flags: swept clear one set per cycle, set by training.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q  <= '0;
            pvld_q <= '0;
        end else if (sweep_clr) begin
            vld_q[ptr_q]  <= 2'b00;
            pvld_q[ptr_q] <= 2'b00;
        end else if (wr_any) begin
            vld_q[head.set][head.slot]  <= 1'b1;
            pvld_q[head.set][head.slot] <= hit;
        end
    end

    assign l_set = bus.pc_now[HASH_DEPTH+2:3];
    assign l_tag = bus.pc_now[TAG_MSB:TAG_LSB];

    // Lookup read of both slots, optionally forwarding the entry being written this cycle.
    always_comb begin
        lk0 = mem[l_set][1'b0];
        lk1 = mem[l_set][1'b1];
        lv  = vld_q[l_set];
        lp  = pvld_q[l_set];
`ifdef BIT_WRITE_BYPASS_EN
        if (wr_any && (head.set == l_set)) begin
            if (head.slot) begin
                lk1   = wr_ent;
                lv[1] = 1'b1;
                lp[1] = hit;
            end else begin
                lk0   = wr_ent;
                lv[0] = 1'b1;
                lp[0] = hit;
            end
        end
`endif
    end

    assign bus.exist1    = (state_q == ST_RUN) & lv[0] & (lk0.tag == l_tag);
    assign bus.exist2    = (state_q == ST_RUN) & lv[1] & (lk1.tag == l_tag);
    assign bus.info1     = lk0.target;
    assign bus.info2     = lk1.target;
    assign bus.past_vld1 = lp[0];
    assign bus.past_vld2 = lp[1];
    assign bus.past1     = lk0.pat;
    assign bus.past2     = lk1.pat;
endmodule

// File: tb/tb_branch_info_table.sv
// Self-checking bench for branch_info_table: update vector table with scoreboard,
// plus directed sequences for sweep length, queue backpressure/order, clear flush,
// en freeze and same-cycle write visibility.
module tb_branch_info_table;
    logic clk = 1'b0;
    logic rstn;
    logic en;
    logic clear;
    logic busy;

    always #5 clk = ~clk;

    branch_info_table_if #(.ADDR_WIDTH(32), .PARA_WIDTH(10)) bus ();

    branch_info_table #(
        .ADDR_WIDTH(32), .HASH_DEPTH(5), .HASH_WIDTH(24), .PARA_WIDTH(10)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .en    (en),
        .clear (clear),
        .busy  (busy),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] tgt;
        logic        chk_data;
        logic        exp_exist;
        logic [31:0] exp_info;
        logic        exp_pv;
        logic [9:0]  exp_past;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];
    vec_t sb_q [$];
    vec_t e;

    int errors = 0;
    int checks = 0;
    int n;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive_upd(input logic v, input logic [31:0] pc, input logic t, input logic [31:0] tg);
        bus.upd_valid  = v;
        bus.upd_pc     = pc;
        bus.upd_taken  = t;
        bus.upd_target = tg;
    endtask

    task automatic look(input logic [31:0] pc);
        bus.pc_now = {pc[31:3], 3'b000};
        #1;
    endtask

    // Looks up the pair holding pc and checks the slot selected by pc[2].
    task automatic chk_slot(input string nm, input logic [31:0] pc, input logic chk_data,
                            input logic ex, input logic [31:0] info, input logic pv, input logic [9:0] past);
        look(pc);
        if (pc[2]) begin
            chk({nm, ".exist2"}, 32'(bus.exist2), 32'(ex));
            if (chk_data) begin
                chk({nm, ".info2"}, bus.info2, info);
                chk({nm, ".past_vld2"}, 32'(bus.past_vld2), 32'(pv));
                chk({nm, ".past2"}, 32'(bus.past2), 32'(past));
            end
        end else begin
            chk({nm, ".exist1"}, 32'(bus.exist1), 32'(ex));
            if (chk_data) begin
                chk({nm, ".info1"}, bus.info1, info);
                chk({nm, ".past_vld1"}, 32'(bus.past_vld1), 32'(pv));
                chk({nm, ".past1"}, 32'(bus.past1), 32'(past));
            end
        end
    endtask

    // Counts negedges with busy high, bounded so a stuck sweep cannot hang the run.
    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        // Pattern layout {hist, ctr3, ctr2, ctr1, ctr0}; all on pc 0x1C00_0104 (set 0, slot 1) unless noted.
        vecs[0]  = '{32'h1C00_0104, 1'b1, 32'h1C00_0040, 1'b1, 1'b1, 32'h1C00_0040, 1'b0, 10'h055}; // allocate
        vecs[1]  = '{32'h1C00_0104, 1'b1, 32'h1C00_0040, 1'b1, 1'b1, 32'h1C00_0040, 1'b1, 10'h156}; // c0 01->10, h=01
        vecs[2]  = '{32'h1C00_0104, 1'b1, 32'h1C00_0040, 1'b1, 1'b1, 32'h1C00_0040, 1'b1, 10'h35A}; // c1 01->10, h=11
        vecs[3]  = '{32'h1C00_0104, 1'b1, 32'h1C00_0040, 1'b1, 1'b1, 32'h1C00_0040, 1'b1, 10'h39A}; // c3 01->10
        vecs[4]  = '{32'h1C00_0104, 1'b1, 32'h1C00_0040, 1'b1, 1'b1, 32'h1C00_0040, 1'b1, 10'h3DA}; // c3 10->11
        vecs[5]  = '{32'h1C00_0104, 1'b1, 32'h1C00_0040, 1'b1, 1'b1, 32'h1C00_0040, 1'b1, 10'h3DA}; // c3 saturates
        vecs[6]  = '{32'h1C00_0104, 1'b0, 32'h1C00_0999, 1'b1, 1'b1, 32'h1C00_0040, 1'b1, 10'h29A}; // c3 11->10, h=10
        vecs[7]  = '{32'h1C00_0104, 1'b0, 32'h1C00_0999, 1'b1, 1'b1, 32'h1C00_0040, 1'b1, 10'h08A}; // c2 01->00, h=00
        vecs[8]  = '{32'h1C00_0104, 1'b0, 32'h1C00_0999, 1'b1, 1'b1, 32'h1C00_0040, 1'b1, 10'h089}; // c0 10->01
        vecs[9]  = '{32'h1C00_0104, 1'b0, 32'h1C00_0999, 1'b1, 1'b1, 32'h1C00_0040, 1'b1, 10'h088}; // c0 01->00
        vecs[10] = '{32'h1C00_0104, 1'b0, 32'h1C00_0999, 1'b1, 1'b1, 32'h1C00_0040, 1'b1, 10'h088}; // c0 saturates
        vecs[11] = '{32'h1C00_0104, 1'b1, 32'h1C00_0200, 1'b1, 1'b1, 32'h1C00_0200, 1'b1, 10'h189}; // c0 00->01, h=01
        vecs[12] = '{32'h1C00_0100, 1'b0, 32'h1C00_0777, 1'b0, 1'b0, 32'h0,         1'b0, 10'h000}; // slot0 NT miss
        vecs[13] = '{32'h1C00_0100, 1'b1, 32'h1C00_0500, 1'b1, 1'b1, 32'h1C00_0500, 1'b0, 10'h055}; // slot0 allocate
        vecs[14] = '{32'h2D00_0104, 1'b1, 32'h2D00_0010, 1'b1, 1'b1, 32'h2D00_0010, 1'b0, 10'h055}; // tag replace
        vecs[15] = '{32'h1C00_0104, 1'b0, 32'h1C00_0999, 1'b0, 1'b0, 32'h0,         1'b0, 10'h000}; // old tag gone
        vecs[16] = '{32'h1C00_00FC, 1'b1, 32'h1C00_00AA, 1'b1, 1'b1, 32'h1C00_00AA, 1'b0, 10'h055}; // last set

        rstn  = 1'b0;
        en    = 1'b1;
        clear = 1'b0;
        drive_upd(1'b0, 32'h0, 1'b0, 32'h0);
        bus.pc_now = 32'h1C00_0100;
        #1;
        chk("reset.busy", 32'(busy), 32'd1);
        chk("reset.upd_ready", 32'(bus.upd_ready), 32'd1);
        chk("reset.exist1", 32'(bus.exist1), 32'd0);
        chk("reset.exist2", 32'(bus.exist2), 32'd0);
        chk("reset.past_vld1", 32'(bus.past_vld1), 32'd0);
        chk("reset.past_vld2", 32'(bus.past_vld2), 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        count_busy(n);
        chk("reset.busy_cycles", 32'(n), 32'd32);

        // Update vectors: expectation queued at drive, compared once the entry has popped.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive_upd(1'b1, vecs[i].pc, vecs[i].taken, vecs[i].tgt);
            sb_q.push_back(vecs[i]);
            @(negedge clk);
            drive_upd(1'b0, 32'h0, 1'b0, 32'h0);
            @(negedge clk);
            e = sb_q.pop_front();
            chk_slot($sformatf("vec%0d", i), e.pc, e.chk_data, e.exp_exist, e.exp_info, e.exp_pv, e.exp_past);
        end

        // Backpressure and ordering: fill the queue during the sweep after a clear.
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        look(32'h2D00_0100);
        chk("init.busy", 32'(busy), 32'd1);
        chk("init.exist_gated", 32'(bus.exist2), 32'd0);
        drive_upd(1'b1, 32'h1C00_0104, 1'b1, 32'h1C00_0111);
        chk("order.ready_empty", 32'(bus.upd_ready), 32'd1);
        @(negedge clk);
        drive_upd(1'b1, 32'h1C00_0104, 1'b1, 32'h1C00_0222);
        chk("order.ready_one", 32'(bus.upd_ready), 32'd1);
        @(negedge clk);
        drive_upd(1'b1, 32'h1C00_0104, 1'b1, 32'h1C00_0333);
        chk("order.ready_full", 32'(bus.upd_ready), 32'd0);
        @(negedge clk);
        drive_upd(1'b0, 32'h0, 1'b0, 32'h0);
        count_busy(n);
        chk("order.sweep_done", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk_slot("order", 32'h1C00_0104, 1'b1, 1'b1, 32'h1C00_0222, 1'b1, 10'h156);

        // Write landing on the set being looked up.
        @(negedge clk);
        drive_upd(1'b1, 32'h1C00_0104, 1'b1, 32'h1C00_0222);
        @(negedge clk);
        drive_upd(1'b0, 32'h0, 1'b0, 32'h0);
        look(32'h1C00_0100);
`ifdef BIT_WRITE_BYPASS_EN
        chk("bypass.same_cycle", 32'(bus.past2), 32'h35A);
`else
        chk("bypass.same_cycle", 32'(bus.past2), 32'h156);
`endif
        @(negedge clk);
        #1;
        chk("bypass.next_cycle", 32'(bus.past2), 32'h35A);

        // en low: an offered update is not taken.
        @(negedge clk);
        en = 1'b0;
        drive_upd(1'b1, 32'h1C00_0104, 1'b1, 32'h1C00_0999);
        repeat (2) @(negedge clk);
        en = 1'b1;
        drive_upd(1'b0, 32'h0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        chk_slot("en_freeze", 32'h1C00_0104, 1'b1, 1'b1, 32'h1C00_0222, 1'b1, 10'h35A);

        // Clear with one entry queued and a concurrent push: both lost.
        @(negedge clk);
        drive_upd(1'b1, 32'h1C00_00FC, 1'b1, 32'h1C00_00AA);
        @(negedge clk);
        drive_upd(1'b1, 32'h1C00_00FC, 1'b1, 32'h1C00_00BB);
        @(negedge clk);
        drive_upd(1'b1, 32'h1C00_0104, 1'b1, 32'h1C00_0444);
        clear = 1'b1;
        chk_slot("clear.first_applied", 32'h1C00_00FC, 1'b1, 1'b1, 32'h1C00_00AA, 1'b0, 10'h055);
        @(negedge clk);
        clear = 1'b0;
        drive_upd(1'b0, 32'h0, 1'b0, 32'h0);
        look(32'h1C00_00F8);
        chk("clear.upd_ready", 32'(bus.upd_ready), 32'd1);
        chk("clear.exist_gated", 32'(bus.exist2), 32'd0);
        count_busy(n);
        chk("clear.busy_cycles", 32'(n), 32'd32);
        repeat (4) @(negedge clk);
        chk_slot("clear.set31_gone", 32'h1C00_00FC, 1'b0, 1'b0, 32'h0, 1'b0, 10'h0);
        chk_slot("clear.set0_gone", 32'h1C00_0104, 1'b0, 1'b0, 32'h0, 1'b0, 10'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
